// File: rtl/alu_shift_mclk.sv
// ============================================================================
// alu_shift_mclk : multi-clock SHLD/SHRD (+ optional RCL/RCR, macro
//                  ALU_SHIFT_MCLK_RCX_EN) with a byte step then a bit step
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_shift_mclk #(
  parameter int EXCEPT_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    except,
  input  logic                    except_thread,
  input  logic                    in_en,
  input  logic                    in_thread,
  input  logic [1:0]              in_op,
  input  logic                    in_sz,
  input  logic [63:0]             in_val1,
  input  logic [63:0]             in_val2,
  input  logic [5:0]              in_cnt,
  input  logic                    in_cf,
  output logic                    in_busy,
  output logic                    nDataAlt,
  input  logic                    out_ack,
  output logic                    out_thread,
  output logic [65:0]             valRes,
  output logic [EXCEPT_WIDTH-1:0] retData
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STG1 = 2'd1,
    ST_STG2 = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SHLD = 2'd0;
  localparam logic [1:0] OP_SHRD = 2'd1;
  localparam logic [1:0] OP_RCL  = 2'd2;
  localparam logic [1:0] OP_RCR  = 2'd3;

  state_t                  r_state;
  state_t                  w_next;
  logic [129:0]            r_work;
  logic                    r_left;
  logic                    r_sz;
  logic                    r_cf;
  logic                    r_v1_msb;
  logic                    r_thread;
  logic [5:0]              r_cnt;
  logic [65:0]             r_val_res;
  logic [EXCEPT_WIDTH-1:0] r_ret_data;

  logic                    w_accept;
  logic                    w_flush;
  logic                    w_bypass;
  logic [5:0]              w_cnt;
  logic [129:0]            w_work0;
  logic [129:0]            w_byte;
  logic [129:0]            w_bit;
  logic [63:0]             w_res;
  logic                    w_carry;
  logic                    w_msb;
  logic                    w_zero;
  logic                    w_ovf;
  logic [5:0]              w_flags;

  assign w_accept = (r_state == ST_IDLE) && in_en;
  assign w_flush  = except && (except_thread == r_thread) && (r_state != ST_IDLE);
  // Masked count is always below W+1, so the rotate's mod-(W+1) reduces to the mask.
  assign w_cnt    = in_sz ? in_cnt : {1'b0, in_cnt[4:0]};

`ifdef ALU_SHIFT_MCLK_RCX_EN
  assign w_bypass = 1'b0;
`else
  assign w_bypass = in_op[1];
`endif

  // Left ops keep the carry at bit 129 and the result just below it; right ops
  // keep the carry at bit 0 and the result just above it. Rotates duplicate the
  // (W+1)-bit {cf,val} ring so a plain shift yields the rotation.
  always_comb begin
    w_work0 = '0;
    case ({in_op, in_sz})
      {OP_SHLD, 1'b1}: w_work0 = {1'b0, in_val1, in_val2, 1'b0};
      {OP_SHLD, 1'b0}: w_work0 = {1'b0, in_val1[31:0], in_val2[31:0], 65'd0};
      {OP_SHRD, 1'b1}: w_work0 = {1'b0, in_val2, in_val1, 1'b0};
      {OP_SHRD, 1'b0}: w_work0 = {65'd0, in_val2[31:0], in_val1[31:0], 1'b0};
`ifdef ALU_SHIFT_MCLK_RCX_EN
      {OP_RCL, 1'b1}:  w_work0 = {in_cf, in_val1, in_cf, in_val1};
      {OP_RCL, 1'b0}:  w_work0 = {in_cf, in_val1[31:0], in_cf, in_val1[31:0], 64'd0};
      {OP_RCR, 1'b1}:  w_work0 = {in_val1, in_cf, in_val1, in_cf};
      {OP_RCR, 1'b0}:  w_work0 = {64'd0, in_val1[31:0], in_cf, in_val1[31:0], in_cf};
`endif
      default:         w_work0 = '0;
    endcase
  end

  assign w_byte = r_left ? (r_work << {r_cnt[5:3], 3'b000}) : (r_work >> {r_cnt[5:3], 3'b000});
  assign w_bit  = r_left ? (r_work << r_cnt[2:0]) : (r_work >> r_cnt[2:0]);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case ({r_left, r_sz})
      2'b11: begin w_res = w_bit[128:65];           w_carry = w_bit[129]; end
      2'b10: begin w_res = {32'd0, w_bit[128:97]};  w_carry = w_bit[129]; end
      2'b01: begin w_res = w_bit[64:1];             w_carry = w_bit[0];   end
      default: begin w_res = {32'd0, w_bit[32:1]};  w_carry = w_bit[0];   end
    endcase
    if (r_cnt == 6'd0) w_carry = r_cf;
  end

  assign w_msb   = r_sz ? w_res[63] : w_res[31];
  assign w_zero  = (w_res == 64'd0);
  assign w_ovf   = (r_cnt == 6'd1) ? (w_msb ^ r_v1_msb) : 1'b0;
  assign w_flags = {w_carry, w_ovf, 1'b0, w_msb, w_zero, 1'b0};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_en) w_next = w_bypass ? ST_DONE : ST_STG1;
      ST_STG1: w_next = ST_STG2;
      ST_STG2: w_next = ST_DONE;
      ST_DONE: if (out_ack) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_work     <= '0;
      r_left     <= 1'b0;
      r_sz       <= 1'b0;
      r_cf       <= 1'b0;
      r_v1_msb   <= 1'b0;
      r_thread   <= 1'b0;
      r_cnt      <= '0;
      r_val_res  <= '0;
      r_ret_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work   <= w_work0;
        r_left   <= ~in_op[0];
        r_sz     <= in_sz;
        r_cf     <= in_cf;
        r_v1_msb <= in_sz ? in_val1[63] : in_val1[31];
        r_thread <= in_thread;
        r_cnt    <= w_cnt;
        if (w_bypass) begin
          r_val_res  <= {^in_val1, 1'b0, in_val1};
          r_ret_data <= EXCEPT_WIDTH'({in_cf, 5'b00000});
        end
      end
      if (r_state == ST_STG1) r_work <= w_byte;
      if (r_state == ST_STG2) begin
        r_val_res  <= {^w_res, 1'b0, w_res};
        r_ret_data <= EXCEPT_WIDTH'(w_flags);
      end
    end
  end

  assign in_busy    = (r_state != ST_IDLE);
  assign nDataAlt   = (r_state != ST_DONE);
  assign out_thread = r_thread;
  assign valRes     = r_val_res;
  assign retData    = r_ret_data;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_mclk.sv
// ============================================================================
// tb_alu_shift_mclk : directed + randomized bench with a bit-serial shift model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_shift_mclk;

  logic        clk;
  logic        rst;
  logic        except;
  logic        except_thread;
  logic        in_en;
  logic        in_thread;
  logic [1:0]  in_op;
  logic        in_sz;
  logic [63:0] in_val1;
  logic [63:0] in_val2;
  logic [5:0]  in_cnt;
  logic        in_cf;
  logic        in_busy;
  logic        nDataAlt;
  logic        out_ack;
  logic        out_thread;
  logic [65:0] valRes;
  logic [8:0]  retData;

  int n_cmp = 0;
  int n_mis = 0;

  alu_shift_mclk #(.EXCEPT_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
    .in_en(in_en), .in_thread(in_thread), .in_op(in_op), .in_sz(in_sz),
    .in_val1(in_val1), .in_val2(in_val2), .in_cnt(in_cnt), .in_cf(in_cf),
    .in_busy(in_busy), .nDataAlt(nDataAlt), .out_ack(out_ack),
    .out_thread(out_thread), .valRes(valRes), .retData(retData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shifts one bit at a time, straight from the architectural definition.
  function automatic void model(input logic [1:0] op, input logic sz, input logic [63:0] v1,
                                input logic [63:0] v2, input logic [5:0] cnt, input logic cf,
                                output logic [63:0] res, output logic [5:0] flags, output int lat);
    int w = sz ? 64 : 32;
    int c = sz ? int'(cnt) : int'(cnt) % 32;
    logic [63:0] mask = sz ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [63:0] a = v1 & mask;
    logic [63:0] b = v2 & mask;
    logic carry = cf;
    logic msb0;
    logic t;
    logic ovf;
`ifndef ALU_SHIFT_MCLK_RCX_EN
    if (op >= 2'd2) begin
      res = v1; flags = {cf, 5'b00000}; lat = 1;
      return;
    end
`endif
    lat = 3;
    if (op >= 2'd2) c = c % (w + 1);
    msb0 = a[w-1];
    for (int i = 0; i < c; i++) begin
      case (op)
        2'd0: begin carry = a[w-1]; a = ((a << 1) | 64'(b[w-1])) & mask; b = (b << 1) & mask; end
        2'd1: begin carry = a[0]; a = (a >> 1) | (64'(b[0]) << (w-1)); b = b >> 1; end
        2'd2: begin t = a[w-1]; a = ((a << 1) | 64'(carry)) & mask; carry = t; end
        default: begin t = a[0]; a = (a >> 1) | (64'(carry) << (w-1)); carry = t; end
      endcase
    end
    res   = a;
    ovf   = (c == 1) ? (a[w-1] ^ msb0) : 1'b0;
    flags = {carry, ovf, 1'b0, a[w-1], (a == 64'd0), 1'b0};
  endfunction

  task automatic drive(input logic [1:0] op, input logic sz, input logic [63:0] v1,
                       input logic [63:0] v2, input logic [5:0] cnt, input logic cf, input logic thr);
    in_op = op; in_sz = sz; in_val1 = v1; in_val2 = v2; in_cnt = cnt; in_cf = cf; in_thread = thr;
    in_en = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic sz, input logic [63:0] v1,
                        input logic [63:0] v2, input logic [5:0] cnt, input logic cf, input logic thr);
    logic [63:0] er;
    logic [5:0]  ef;
    int          el;
    int          lat;
    model(op, sz, v1, v2, cnt, cf, er, ef, el);
    @(negedge clk);
    drive(op, sz, v1, v2, cnt, cf, thr);
    @(negedge clk);
    in_en = 1'b0;
    in_val1 = 64'(~v1); in_val2 = 64'(~v2); in_cf = ~cf;
    lat = 1;
    while (nDataAlt !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},   66'(lat), 66'(el));
    check({tag, "_res"},   valRes, {^er, 1'b0, er});
    check({tag, "_flags"}, 66'(retData), 66'({3'b000, ef}));
    check({tag, "_thr"},   66'(out_thread), 66'(thr));
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check({tag, "_idle"},  66'(in_busy), 66'(0));
  endtask

  initial begin
    logic [63:0] er;
    logic [5:0]  ef;
    int          el;
    int          waitc;
    logic        seen;

    rst = 1'b0; except = 1'b0; except_thread = 1'b0; in_en = 1'b0; in_thread = 1'b0;
    in_op = 2'd0; in_sz = 1'b0; in_val1 = '0; in_val2 = '0; in_cnt = '0; in_cf = 1'b0; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_busy",  66'(in_busy), 66'(0));
    check("rst_ndata", 66'(nDataAlt), 66'(1));
    check("rst_val",   valRes, 66'(0));
    check("rst_ret",   66'(retData), 66'(0));
    check("rst_thr",   66'(out_thread), 66'(0));

    run_op("shld64", 2'd0, 1'b1, 64'h8000_0000_0000_0001, 64'hF000_0000_0000_0000, 6'd4, 1'b0, 1'b0);
    run_op("shrd32", 2'd1, 1'b0, 64'h0000_0000_0000_00F1, 64'h0000_0000_0000_0002, 6'd36, 1'b1, 1'b1);
    run_op("rcl32",  2'd2, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 6'd1, 1'b0, 1'b0);
    run_op("rcr64",  2'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0, 6'd63, 1'b1, 1'b1);
    run_op("shld_c0", 2'd0, 1'b1, 64'hDEAD_BEEF_0000_0000, 64'h1234, 6'd0, 1'b1, 1'b0);
    run_op("shrd_c1", 2'd1, 1'b1, 64'h8000_0000_0000_0001, 64'h1, 6'd1, 1'b0, 1'b0);

    // Flush the matching thread while in STG2: no result beat.
    @(negedge clk);
    drive(2'd0, 1'b1, 64'h1111, 64'h2222, 6'd9, 1'b0, 1'b1);
    @(negedge clk); in_en = 1'b0;
    @(negedge clk);
    except = 1'b1; except_thread = 1'b1;
    @(negedge clk); except = 1'b0;
    check("flush_busy",  66'(in_busy), 66'(0));
    check("flush_ndata", 66'(nDataAlt), 66'(1));
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (nDataAlt === 1'b0) seen = 1'b1; end
    check("flush_nopulse", 66'(seen), 66'(0));

    // Flush of the other thread must not disturb the op.
    model(2'd0, 1'b1, 64'h1111, 64'h2222, 6'd9, 1'b0, er, ef, el);
    @(negedge clk);
    drive(2'd0, 1'b1, 64'h1111, 64'h2222, 6'd9, 1'b0, 1'b1);
    @(negedge clk); in_en = 1'b0;
    @(negedge clk);
    except = 1'b1; except_thread = 1'b0;
    @(negedge clk); except = 1'b0;
    check("xflush_ndata", 66'(nDataAlt), 66'(0));
    check("xflush_res",   valRes, {^er, 1'b0, er});

    // Hold in DONE with in_en pulsing: nothing accepted, result stable.
    for (int i = 0; i < 5; i++) begin
      in_en = i[0]; in_val1 = {$urandom, $urandom}; in_cnt = 6'($urandom);
      @(negedge clk);
      check("hold_res",  valRes, {^er, 1'b0, er});
      check("hold_busy", 66'(in_busy), 66'(1));
    end
    in_en = 1'b1; out_ack = 1'b1;
    @(negedge clk);
    in_en = 1'b0; out_ack = 1'b0;
    check("ack_same_cycle_no_accept", 66'(in_busy), 66'(0));

    // Reset during STG1 abandons the op.
    @(negedge clk);
    drive(2'd1, 1'b1, 64'hFFFF, 64'hAAAA, 6'd5, 1'b1, 1'b1);
    @(negedge clk); in_en = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("midrst_busy",  66'(in_busy), 66'(0));
    check("midrst_ndata", 66'(nDataAlt), 66'(1));
    check("midrst_val",   valRes, 66'(0));
    check("midrst_thr",   66'(out_thread), 66'(0));

    // Flush while IDLE does not block an accept.
    @(negedge clk);
    drive(2'd0, 1'b0, 64'h55, 64'h66, 6'd3, 1'b0, 1'b0);
    except = 1'b1; except_thread = 1'b0;
    @(negedge clk); in_en = 1'b0; except = 1'b0;
    check("idleflush_accept", 66'(in_busy), 66'(1));
    waitc = 0;
    while (nDataAlt !== 1'b0 && waitc < 10) begin @(negedge clk); waitc++; end
    check("idleflush_done", 66'(nDataAlt), 66'(0));
    out_ack = 1'b1; @(negedge clk); out_ack = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             6'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
